// File: rtl/bitrev_pkg.sv
// Shared types and helpers for the bit-reversal reorder buffer.
package bitrev_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_t;

  localparam int MAX_K = 32;

  // Mirrors bits [k-1:0] of x; bits above k-1 come back as zero.
  function automatic logic [MAX_K-1:0] bitrev_fn(input logic [MAX_K-1:0] x, input int k);
    logic [MAX_K-1:0] rev;
    rev = {<<{x}};
    return rev >> (MAX_K - k);
  endfunction

endpackage

// File: rtl/bitrev_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
module bitrev_ram #(
  parameter int AW = 11,
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/bitrev.sv
// Ping-pong frame buffer that re-emits each N-word frame in bit-reversed index order.
module bitrev
  import bitrev_pkg::*;
#(
  parameter int K  = 10,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          ready_o,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  input  logic          ready_i
);

  bank_state_t   r_bankState [2];
  bank_state_t   w_bankStateNext [2];
  logic [K-1:0]  r_wrPtr, r_rdPtr, r_outPtr;
  logic          r_wrBank, r_rdBank, r_outBank;
  logic          r_ready;
  logic          r_rdPending;
  logic          r_outValid, r_skidValid;
  logic [DW-1:0] r_outData, r_skidData;

  logic          w_wrFire, w_rdIssue, w_outFire, w_rdBankReady, w_wrBankNext;
  logic [1:0]    w_occ;
  logic [K-1:0]  w_rdAddrLo;
  logic [DW-1:0] w_ramData;

  assign w_wrFire      = valid_i && r_ready;
  assign w_outFire     = r_outValid && ready_i;
  assign w_rdBankReady = (r_bankState[r_rdBank] == BANK_FULL) ||
                         (r_bankState[r_rdBank] == BANK_DRAINING);
  // Reads are credit-limited so in-flight words always fit in output + skid.
  assign w_occ         = 2'(r_outValid) + 2'(r_skidValid) + 2'(r_rdPending);
  assign w_rdIssue     = w_rdBankReady && ((w_occ - 2'(w_outFire)) < 2'd2);
  assign w_wrBankNext  = r_wrBank ^ (w_wrFire && (r_wrPtr == '1));
  assign w_rdAddrLo    = K'(bitrev_fn(MAX_K'(r_rdPtr), K));

  // Write side only touches EMPTY/FILLING banks, read side only FULL/DRAINING ones.
  always_comb begin
    w_bankStateNext = r_bankState;
    if (w_wrFire)
      w_bankStateNext[r_wrBank] = (r_wrPtr == '1) ? BANK_FULL : BANK_FILLING;
    if (w_rdIssue && (r_bankState[r_rdBank] == BANK_FULL))
      w_bankStateNext[r_rdBank] = BANK_DRAINING;
    if (w_outFire && (r_outPtr == '1))
      w_bankStateNext[r_outBank] = BANK_EMPTY;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bankState[0] <= BANK_EMPTY;
      r_bankState[1] <= BANK_EMPTY;
      r_ready        <= 1'b0;
      r_wrPtr        <= '0;
      r_wrBank       <= 1'b0;
      r_rdPtr        <= '0;
      r_rdBank       <= 1'b0;
      r_outPtr       <= '0;
      r_outBank      <= 1'b0;
      r_rdPending    <= 1'b0;
    end else begin
      r_bankState <= w_bankStateNext;
      r_ready     <= (w_bankStateNext[w_wrBankNext] == BANK_EMPTY) ||
                     (w_bankStateNext[w_wrBankNext] == BANK_FILLING);
      r_rdPending <= w_rdIssue;
      if (w_wrFire) begin
        r_wrPtr <= r_wrPtr + K'(1);
        if (r_wrPtr == '1) r_wrBank <= ~r_wrBank;
      end
      if (w_rdIssue) begin
        r_rdPtr <= r_rdPtr + K'(1);
        if (r_rdPtr == '1) r_rdBank <= ~r_rdBank;
      end
      if (w_outFire) begin
        r_outPtr <= r_outPtr + K'(1);
        if (r_outPtr == '1) r_outBank <= ~r_outBank;
      end
    end
  end

  // Output register fed from skid first, then from the RAM read of last cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_outValid  <= 1'b0;
      r_outData   <= '0;
      r_skidValid <= 1'b0;
      r_skidData  <= '0;
    end else if (!r_outValid || ready_i) begin
      if (r_skidValid) begin
        r_outValid <= 1'b1;
        r_outData  <= r_skidData;
        if (r_rdPending) r_skidData  <= w_ramData;
        else             r_skidValid <= 1'b0;
      end else if (r_rdPending) begin
        r_outValid <= 1'b1;
        r_outData  <= w_ramData;
      end else begin
        r_outValid <= 1'b0;
      end
    end else if (r_rdPending) begin
      r_skidValid <= 1'b1;
      r_skidData  <= w_ramData;
    end
  end

  bitrev_ram #(
    .AW(K + 1),
    .DW(DW)
  ) u_ram (
    .i_clk   (clk_i),
    .i_we    (w_wrFire),
    .i_waddr ({r_wrBank, r_wrPtr}),
    .i_wdata (data_i),
    .i_re    (w_rdIssue),
    .i_raddr ({r_rdBank, w_rdAddrLo}),
    .o_rdata (w_ramData)
  );

  assign ready_o = r_ready;
  assign valid_o = r_outValid;
  assign data_o  = r_outData;

endmodule

// File: tb/tb_bitrev.sv
// Self-checking bench for bitrev: scoreboard of bit-reversed frames across several stream scenarios.
module tb_bitrev;

  localparam int K  = 10;
  localparam int N  = 1 << K;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          validI = 1'b0, readyI = 1'b0;
  logic          readyO, validO;
  logic [DW-1:0] dataI = '0, dataO;

  logic       v1 = 1'b0, ri1 = 1'b0, ro1, vo1;
  logic [7:0] d1 = '0, do1;
  logic       v2 = 1'b0, ri2 = 1'b0, ro2, vo2;
  logic [7:0] d2 = '0, do2;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] expQ [$];
  logic [DW-1:0] frameBuf [N];
  logic [7:0]    expSmall [$];
  int            inIdx = 0, acceptedCnt = 0, deliveredCnt = 0;
  logic          prevStall = 1'b0;
  logic [DW-1:0] prevData = '0;

  always #5 clk = ~clk;

  bitrev #(.K(K), .DW(DW)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(validI), .data_i(dataI),
    .ready_o(readyO), .valid_o(validO), .data_o(dataO), .ready_i(readyI)
  );

  bitrev #(.K(1), .DW(8)) dutK1 (
    .clk_i(clk), .rst_i(rst), .valid_i(v1), .data_i(d1),
    .ready_o(ro1), .valid_o(vo1), .data_o(do1), .ready_i(ri1)
  );

  bitrev #(.K(2), .DW(8)) dutK2 (
    .clk_i(clk), .rst_i(rst), .valid_i(v2), .data_i(d2),
    .ready_o(ro2), .valid_o(vo2), .data_o(do2), .ready_i(ri2)
  );

  function automatic int tbRev(input int v, input int k);
    int r = 0;
    for (int i = 0; i < k; i++)
      if (((v >> i) & 1) == 1) r |= (1 << (k - 1 - i));
    return r;
  endfunction

  task automatic clearModel();
    expQ.delete();
    inIdx        = 0;
    acceptedCnt  = 0;
    deliveredCnt = 0;
    prevStall    = 1'b0;
  endtask

  // One cycle on the main DUT, entered and left at a falling edge.
  task automatic applyStimulus(input bit offer, input logic [DW-1:0] word, input bit rdy);
    logic [DW-1:0] exp;
    validI = offer;
    dataI  = word;
    readyI = rdy;
    #1;
    if (prevStall) begin
      checks++;
      if (validO !== 1'b1 || dataO !== prevData) begin
        errors++;
        $display("[TB] FAIL stall_hold: valid=%b data=%0d, required valid=1 data=%0d", validO, dataO, prevData);
      end
    end
    if (validO && rdy) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_output: data=%0d, required no output", dataO);
      end else begin
        exp = expQ.pop_front();
        if (dataO !== exp) begin
          errors++;
          $display("[TB] FAIL out_word[%0d]: data=%0d, required %0d", deliveredCnt, dataO, exp);
        end
      end
      deliveredCnt++;
    end
    if (offer && readyO) begin
      frameBuf[inIdx] = word;
      acceptedCnt++;
      if (inIdx == N - 1) begin
        for (int m = 0; m < N; m++) expQ.push_back(frameBuf[tbRev(m, K)]);
        inIdx = 0;
      end else begin
        inIdx++;
      end
    end
    prevStall = validO && !rdy;
    prevData  = dataO;
    @(negedge clk);
  endtask

  task automatic drainAll(input int budget);
    int c = 0;
    while ((expQ.size() > 0 || validO) && c < budget) begin
      applyStimulus(1'b0, '0, 1'b1);
      c++;
    end
    checks++;
    if (expQ.size() > 0 || validO) begin
      errors++;
      $display("[TB] FAIL drain_timeout: %0d words left, required 0", expQ.size());
    end
  endtask

  task automatic applyReset();
    validI = 1'b0;
    readyI = 1'b0;
    rst    = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clearModel();
    @(negedge clk);
  endtask

  task automatic test_reset();
    validI = 1'b0;
    readyI = 1'b0;
    rst    = 1'b1;
    repeat (2) @(negedge clk);
    checks += 4;
    if (readyO !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: %b, required 0", readyO); end
    if (validO !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: %b, required 0", validO); end
    if (dataO !== '0) begin errors++; $display("[TB] FAIL reset_data: %0d, required 0", dataO); end
    if (ro1 !== 1'b0 || ro2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_small_ready: %b%b, required 00", ro1, ro2); end
    rst = 1'b0;
    clearModel();
    @(negedge clk);
    checks++;
    if (readyO !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_reset: %b, required 1", readyO); end
  endtask

  task automatic test_single_frame();
    bit earlyValid = 1'b0;
    int lat = 1;
    clearModel();
    for (int n = 0; n < N; n++) begin
      if (validO) earlyValid = 1'b1;
      applyStimulus(1'b1, DW'(n), 1'b1);
    end
    checks += 3;
    if (earlyValid) begin errors++; $display("[TB] FAIL early_valid: valid seen before frame end, required none"); end
    if (acceptedCnt != N) begin errors++; $display("[TB] FAIL frame_accept: %0d, required %0d", acceptedCnt, N); end
    while (!validO && lat <= 5) begin
      applyStimulus(1'b0, '0, 1'b1);
      lat++;
    end
    if (lat > 3) begin errors++; $display("[TB] FAIL latency: %0d cycles, required <= 3", lat); end
    drainAll(3000);
    checks++;
    if (deliveredCnt != N) begin errors++; $display("[TB] FAIL frame_deliver: %0d, required %0d", deliveredCnt, N); end
  endtask

  task automatic test_back_to_back();
    bit readyDrop = 1'b0;
    clearModel();
    for (int n = 0; n < 2 * N; n++) begin
      if (!readyO) readyDrop = 1'b1;
      applyStimulus(1'b1, DW'(n), 1'b1);
    end
    checks += 2;
    if (readyDrop) begin errors++; $display("[TB] FAIL b2b_ready: ready dropped, required held 1"); end
    if (acceptedCnt != 2 * N) begin errors++; $display("[TB] FAIL b2b_accept: %0d, required %0d", acceptedCnt, 2 * N); end
    drainAll(3000);
    checks++;
    if (deliveredCnt != 2 * N) begin errors++; $display("[TB] FAIL b2b_deliver: %0d, required %0d", deliveredCnt, 2 * N); end
  endtask

  task automatic test_stall();
    applyReset();
    for (int c = 0; c < 2 * N + 60; c++) applyStimulus(1'b1, DW'(acceptedCnt), 1'b0);
    checks += 3;
    if (acceptedCnt != 2 * N) begin errors++; $display("[TB] FAIL stall_accept: %0d, required %0d", acceptedCnt, 2 * N); end
    if (readyO !== 1'b0) begin errors++; $display("[TB] FAIL stall_ready: %b, required 0", readyO); end
    if (validO !== 1'b1 || dataO !== '0) begin
      errors++;
      $display("[TB] FAIL stall_head: valid=%b data=%0d, required valid=1 data=0", validO, dataO);
    end
    drainAll(5000);
    checks++;
    if (deliveredCnt != 2 * N) begin errors++; $display("[TB] FAIL stall_deliver: %0d, required %0d", deliveredCnt, 2 * N); end
  endtask

  task automatic test_random_ready();
    int c = 0;
    clearModel();
    while ((acceptedCnt < 4 * N || expQ.size() > 0 || validO) && c < 20000) begin
      applyStimulus(acceptedCnt < 4 * N, DW'(5000 + acceptedCnt), 1'($urandom_range(0, 1)));
      c++;
    end
    checks += 2;
    if (c >= 20000) begin errors++; $display("[TB] FAIL random_timeout: %0d words left, required 0", expQ.size()); end
    if (deliveredCnt != 4 * N) begin errors++; $display("[TB] FAIL random_deliver: %0d, required %0d", deliveredCnt, 4 * N); end
  endtask

  task automatic test_mid_reset();
    clearModel();
    for (int n = 0; n < 300; n++) applyStimulus(1'b1, DW'(n), 1'b1);
    validI = 1'b0;
    rst    = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (validO !== 1'b0 || readyO !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midreset_outputs: valid=%b ready=%b, required 0 0", validO, readyO);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    clearModel();
    @(negedge clk);
    checks++;
    if (readyO !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ready: %b, required 1", readyO); end
    for (int n = 0; n < N; n++) applyStimulus(1'b1, DW'(7000 + n), 1'b1);
    drainAll(3000);
    checks++;
    if (deliveredCnt != N) begin errors++; $display("[TB] FAIL midreset_deliver: %0d, required %0d", deliveredCnt, N); end
  endtask

  task automatic test_k1();
    logic [7:0] words [2];
    logic [7:0] bufK1 [2];
    logic [7:0] exp;
    int sent = 0, got = 0;
    words = '{8'h0A, 8'h0B};
    expSmall.delete();
    ri1 = 1'b1;
    for (int c = 0; c < 20 && got < 2; c++) begin
      v1 = (sent < 2);
      if (sent < 2) d1 = words[sent];
      #1;
      if (vo1 && ri1) begin
        checks++;
        if (expSmall.size() == 0) begin
          errors++;
          $display("[TB] FAIL k1_unexpected: %0h, required no output", do1);
        end else begin
          exp = expSmall.pop_front();
          if (do1 !== exp) begin errors++; $display("[TB] FAIL k1_word[%0d]: %0h, required %0h", got, do1, exp); end
        end
        got++;
      end
      if (v1 && ro1) begin
        bufK1[sent] = d1;
        sent++;
        if (sent == 2) for (int m = 0; m < 2; m++) expSmall.push_back(bufK1[tbRev(m, 1)]);
      end
      @(negedge clk);
    end
    v1 = 1'b0;
    checks++;
    if (got != 2) begin errors++; $display("[TB] FAIL k1_count: %0d, required 2", got); end
  endtask

  task automatic test_k2();
    logic [7:0] bufK2 [4];
    logic [7:0] exp;
    int sent = 0, got = 0;
    expSmall.delete();
    ri2 = 1'b1;
    for (int c = 0; c < 30 && got < 4; c++) begin
      v2 = (sent < 4);
      d2 = 8'(sent);
      #1;
      if (vo2 && ri2) begin
        checks++;
        if (expSmall.size() == 0) begin
          errors++;
          $display("[TB] FAIL k2_unexpected: %0d, required no output", do2);
        end else begin
          exp = expSmall.pop_front();
          if (do2 !== exp) begin errors++; $display("[TB] FAIL k2_word[%0d]: %0d, required %0d", got, do2, exp); end
        end
        got++;
      end
      if (v2 && ro2) begin
        bufK2[sent] = d2;
        sent++;
        if (sent == 4) for (int m = 0; m < 4; m++) expSmall.push_back(bufK2[tbRev(m, 2)]);
      end
      @(negedge clk);
    end
    v2 = 1'b0;
    checks++;
    if (got != 4) begin errors++; $display("[TB] FAIL k2_count: %0d, required 4", got); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall();
    test_random_ready();
    test_mid_reset();
    test_k1();
    test_k2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
